// File: rtl/boxcar_decimator_mc.sv
// Multi-channel boxcar decimator: averages 2^k interleaved samples per
// channel and emits one rounded, saturated result per channel per block.
module boxcar_decimator_mc #(
    parameter int DATA_W     = 24,
    parameter int CH_NUM     = 2,
    parameter int MAX_LOG2_R = 7,
    parameter bit ROUND_EN   = 1'b1,
    localparam int KW = (MAX_LOG2_R > 0) ? $clog2(MAX_LOG2_R + 1) : 1,
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     valid_in,
    input  logic                     first_in,
    input  logic [KW-1:0]            log2_ratio,
    input  logic                     clear,
    output logic signed [DATA_W-1:0] data_out,
    output logic [CW-1:0]            ch_out,
    output logic                     valid_out,
    output logic                     align_err
);
    localparam int AW = DATA_W + MAX_LOG2_R;
    localparam int FW = (MAX_LOG2_R > 0) ? MAX_LOG2_R : 1;
    localparam logic signed [AW:0] SAT_MAX =
        {{(MAX_LOG2_R + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN =
        {{(MAX_LOG2_R + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [AW-1:0] r_acc [CH_NUM];
    logic [CW-1:0]        r_ch_idx;
    logic [FW-1:0]        r_frame_cnt;
    logic [KW-1:0]        r_k_act;

    logic signed [DATA_W-1:0] r_data_out;
    logic [CW-1:0]            r_ch_out;
    logic                     r_valid_out;
    logic                     r_align_err;

    logic                 w_resync;
    logic [CW-1:0]        w_ch;
    logic [FW-1:0]        w_frame;
    logic                 w_start;
    logic [KW-1:0]        w_k_req;
    logic [KW-1:0]        w_k;
    logic [FW-1:0]        w_frame_last;
    logic                 w_last;
    logic                 w_ch_wrap;
    logic signed [AW-1:0] w_din;
    logic signed [AW-1:0] w_acc_old;
    logic signed [AW-1:0] w_sum;
    logic signed [AW:0]   w_rnd;
    logic signed [AW:0]   w_rsum;
    logic signed [AW:0]   w_res;
    logic signed [DATA_W-1:0] w_sat;

    // A resync treats the current sample as channel 0, frame 0 of a fresh block
    assign w_resync  = valid_in & first_in & (r_ch_idx != '0);
    assign w_ch      = w_resync ? '0 : r_ch_idx;
    assign w_frame   = w_resync ? '0 : r_frame_cnt;
    assign w_start   = (w_ch == '0) && (w_frame == '0);
    assign w_k_req   = (int'(log2_ratio) > MAX_LOG2_R) ?
                       KW'(MAX_LOG2_R) : log2_ratio;
    // The ratio that governs a block is the one seen on its first sample
    assign w_k       = w_start ? w_k_req : r_k_act;
    assign w_frame_last = FW'((32'd1 << w_k) - 32'd1);
    assign w_last    = (w_frame == w_frame_last);
    assign w_ch_wrap = (w_ch == CW'(CH_NUM - 1));

    assign w_din     = data_in;
    assign w_acc_old = w_resync ? '0 : r_acc[w_ch];
    assign w_sum     = w_acc_old + w_din;

    assign w_rnd  = (ROUND_EN && (w_k != '0)) ?
                    ((AW + 1)'(1) << (w_k - 1'b1)) : '0;
    assign w_rsum = {w_sum[AW-1], w_sum} + w_rnd;
    assign w_res  = w_rsum >>> w_k;

    // Clamp the shifted result into the output sample range
    always_comb begin
        w_sat = w_res[DATA_W-1:0];
        if (w_res > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_res < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    // Accumulators, channel/frame position and the active ratio
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_acc[i] <= '0;
            end
            r_ch_idx    <= '0;
            r_frame_cnt <= '0;
            r_k_act     <= '0;
        end else if (clear) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_acc[i] <= '0;
            end
            r_ch_idx    <= '0;
            r_frame_cnt <= '0;
            r_k_act     <= '0;
        end else if (valid_in) begin
            if (w_resync) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    r_acc[i] <= '0;
                end
            end
            r_acc[w_ch] <= w_last ? '0 : w_sum;
            r_ch_idx    <= w_ch_wrap ? '0 : CW'(w_ch + 1'b1);
            if (w_ch_wrap) begin
                r_frame_cnt <= w_last ? '0 : FW'(w_frame + 1'b1);
            end else begin
                r_frame_cnt <= w_frame;
            end
            if (w_start) begin
                r_k_act <= w_k_req;
            end
        end
    end

    // Registered result strobe; data and channel hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out  <= '0;
            r_ch_out    <= '0;
            r_valid_out <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_align_err <= 1'b0;
            if (!clear && valid_in) begin
                r_align_err <= w_resync;
                if (w_last) begin
                    r_valid_out <= 1'b1;
                    r_data_out  <= w_sat;
                    r_ch_out    <= w_ch;
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign ch_out    = r_ch_out;
    assign valid_out = r_valid_out;
    assign align_err = r_align_err;

endmodule

// File: tb/tb_boxcar_decimator_mc.sv
// Bench for boxcar_decimator_mc: rounding and truncating instances run
// side by side against a block-average model of the same stimulus.
module tb_boxcar_decimator_mc;

    localparam int DW = 24;
    localparam int CH = 2;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] data_in;
    logic                 valid_in;
    logic                 first_in;
    logic [2:0]           log2_ratio;
    logic                 clear;

    logic signed [DW-1:0] dout_r, dout_t;
    logic                 ch_r, ch_t;
    logic                 vo_r, vo_t;
    logic                 ae_r, ae_t;

    boxcar_decimator_mc #(
        .DATA_W(DW), .CH_NUM(CH), .MAX_LOG2_R(7), .ROUND_EN(1'b1)
    ) u_dut_r (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .valid_in(valid_in), .first_in(first_in),
        .log2_ratio(log2_ratio), .clear(clear),
        .data_out(dout_r), .ch_out(ch_r),
        .valid_out(vo_r), .align_err(ae_r)
    );

    boxcar_decimator_mc #(
        .DATA_W(DW), .CH_NUM(CH), .MAX_LOG2_R(7), .ROUND_EN(1'b0)
    ) u_dut_t (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .valid_in(valid_in), .first_in(first_in),
        .log2_ratio(log2_ratio), .clear(clear),
        .data_out(dout_t), .ch_out(ch_t),
        .valid_out(vo_t), .align_err(ae_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int d;
    } cap_t;

    cap_t capR[$];
    cap_t capT[$];

    int total = 0;
    int bad   = 0;
    int align_cnt = 0;
    int drv_lr = 0;

    // model state: position within block, block ratio, per-channel sums
    longint m_sum [CH];
    int     m_pos;
    int     m_k;

    // expectation for the cycle after the current step
    bit     exp_v = 0;
    bit     exp_a = 0;
    int     exp_ch = 0;
    longint exp_dr = 0;
    longint exp_dt = 0;
    bit     hold_known = 1;
    int     hold_ch = 0;
    longint hold_dr = 0;
    longint hold_dt = 0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic longint avg(input longint s, input int k,
                                   input bit rnd);
        longint t;
        t = s;
        if (rnd && k > 0) t = t + (longint'(1) << (k - 1));
        t = t >>> k;
        if (t > 8388607) t = 8388607;
        if (t < -8388608) t = -8388608;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_sum[i] = 0;
        m_pos = 0;
        m_k = 0;
        exp_v = 0;
        exp_a = 0;
        hold_known = 1;
        hold_ch = 0;
        hold_dr = 0;
        hold_dt = 0;
    endtask

    task automatic model_step(input bit v, input bit f, input bit clr,
                              input int d, input int lr);
        int ch;
        int fr;
        exp_v = 0;
        exp_a = 0;
        if (clr) begin
            for (int i = 0; i < CH; i++) m_sum[i] = 0;
            m_pos = 0;
            m_k = 0;
            hold_known = 0;
        end else if (v) begin
            if (f && (m_pos % CH) != 0) begin
                exp_a = 1;
                for (int i = 0; i < CH; i++) m_sum[i] = 0;
                m_pos = 0;
            end
            if (m_pos == 0) m_k = (lr > 7) ? 7 : lr;
            ch = m_pos % CH;
            fr = m_pos / CH;
            m_sum[ch] += d;
            if (fr == (1 << m_k) - 1) begin
                exp_v  = 1;
                exp_ch = ch;
                exp_dr = avg(m_sum[ch], m_k, 1'b1);
                exp_dt = avg(m_sum[ch], m_k, 1'b0);
                m_sum[ch] = 0;
            end
            m_pos++;
            if (m_pos == CH * (1 << m_k)) m_pos = 0;
        end
    endtask

    task automatic step(input bit v, input bit f, input int d,
                        input bit clr);
        @(negedge clk);
        #1;
        valid_in   = v;
        first_in   = f;
        data_in    = d[DW-1:0];
        clear      = clr;
        log2_ratio = drv_lr[2:0];
        model_step(v, f, clr, d, drv_lr);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic start_test(input int lr);
        drv_lr = lr;
        step(0, 0, 0, 1);
        idle(1);
        capR.delete();
        capT.delete();
        align_cnt = 0;
    endtask

    task automatic exp_cap(input string nm, input int i, input int ch,
                           input int dr, input int dt);
        if (capR.size() > i && capT.size() > i) begin
            chk({nm, "_ch"}, capR[i].ch, ch);
            chk({nm, "_rnd"}, capR[i].d, dr);
            chk({nm, "_trn"}, capT[i].d, dt);
        end else begin
            chk({nm, "_count"}, capR.size(), i + 1);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_n    = 0;
        valid_in = 0;
        first_in = 0;
        clear    = 0;
        #1;
        chk("rst_mid_data", dout_r, 0);
        chk("rst_mid_ch", ch_r, 0);
        chk("rst_mid_valid", vo_r, 0);
        chk("rst_mid_align", ae_r, 0);
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1;
    endtask

    // cycle-by-cycle comparison of both instances against the model
    always begin
        @(posedge clk);
        #1;
        chk("valid_r", vo_r, exp_v);
        chk("valid_t", vo_t, exp_v);
        chk("align_r", ae_r, exp_a);
        chk("align_t", ae_t, exp_a);
        if (exp_v) begin
            chk("data_r", dout_r, exp_dr);
            chk("data_t", dout_t, exp_dt);
            chk("ch_r", ch_r, exp_ch);
            chk("ch_t", ch_t, exp_ch);
            hold_known = 1;
            hold_ch = exp_ch;
            hold_dr = exp_dr;
            hold_dt = exp_dt;
        end else if (hold_known) begin
            chk("hold_r", dout_r, hold_dr);
            chk("hold_t", dout_t, hold_dt);
            chk("hold_ch", ch_r, hold_ch);
        end
        if (vo_r) capR.push_back('{int'(ch_r), int'(dout_r)});
        if (vo_t) capT.push_back('{int'(ch_t), int'(dout_t)});
        if (ae_r) align_cnt++;
    end

    initial begin
        int d;
        bit v;
        bit f;
        bit c;
        rst_n = 0;
        valid_in = 0;
        first_in = 0;
        data_in = '0;
        clear = 0;
        log2_ratio = '0;
        model_reset();
        #2;
        chk("rst_data", dout_r, 0);
        chk("rst_ch", ch_r, 0);
        chk("rst_valid", vo_r, 0);
        chk("rst_align", ae_r, 0);
        @(negedge clk);
        #1;
        rst_n = 1;
        idle(2);

        // k=3: two constant channels over 8 frames
        start_test(3);
        for (int i = 0; i < 16; i++)
            step(1, i == 0, (i % 2) ? -100 : 100, 0);
        idle(2);
        chk("t1_n", capR.size(), 2);
        exp_cap("t1_o0", 0, 0, 100, 100);
        exp_cap("t1_o1", 1, 1, -100, -100);
        chk("t1_align", align_cnt, 0);

        // k=2 rounding vs truncation
        start_test(2);
        step(1, 1, 1, 0);
        step(1, 0, -1, 0);
        step(1, 0, 1, 0);
        step(1, 0, -1, 0);
        step(1, 0, 1, 0);
        step(1, 0, -1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(2);
        exp_cap("rnd_pos", 0, 0, 1, 0);
        exp_cap("rnd_neg", 1, 1, -1, -1);

        // k=1 at the extremes of the sample range
        start_test(1);
        step(1, 1, 8388607, 0);
        step(1, 0, -8388608, 0);
        step(1, 0, 8388607, 0);
        step(1, 0, -8388608, 0);
        idle(2);
        exp_cap("sat_max", 0, 0, 8388607, 8388607);
        exp_cap("sat_min", 1, 1, -8388608, -8388608);

        // k=0 pass-through
        start_test(0);
        step(1, 1, 5, 0);
        step(1, 0, -7, 0);
        step(1, 0, 9, 0);
        step(1, 0, 11, 0);
        idle(2);
        exp_cap("pass0", 0, 0, 5, 5);
        exp_cap("pass1", 1, 1, -7, -7);
        exp_cap("pass2", 2, 0, 9, 9);
        exp_cap("pass3", 3, 1, 11, 11);

        // ratio change mid-block takes effect at the next block
        start_test(3);
        step(1, 1, 16, 0);
        drv_lr = 1;
        for (int i = 1; i < 16; i++)
            step(1, 0, (i % 2) ? 8 : 16, 0);
        step(1, 0, 2, 0);
        step(1, 0, 10, 0);
        step(1, 0, 4, 0);
        step(1, 0, 20, 0);
        idle(2);
        chk("kchg_n", capR.size(), 4);
        exp_cap("kchg_b0c0", 0, 0, 16, 16);
        exp_cap("kchg_b0c1", 1, 1, 8, 8);
        exp_cap("kchg_b1c0", 2, 0, 3, 3);
        exp_cap("kchg_b1c1", 3, 1, 15, 15);

        // resync on the channel-1 slot, then a clean block
        start_test(2);
        step(1, 1, 7, 0);
        step(1, 0, 7, 0);
        step(1, 0, 7, 0);
        for (int i = 0; i < 8; i++)
            step(1, i == 0, (i % 2) ? -4 : 4, 0);
        idle(2);
        chk("sync_align", align_cnt, 1);
        chk("sync_n", capR.size(), 2);
        exp_cap("sync_c0", 0, 0, 4, 4);
        exp_cap("sync_c1", 1, 1, -4, -4);

        // asynchronous reset in the middle of a block
        start_test(0);
        step(1, 1, 1234, 0);
        drv_lr = 2;
        step(1, 0, 55, 0);
        step(1, 0, 66, 0);
        step(1, 0, 77, 0);
        pulse_reset();
        capR.delete();
        capT.delete();
        drv_lr = 1;
        step(1, 1, 10, 0);
        step(1, 0, 20, 0);
        step(1, 0, 30, 0);
        step(1, 0, 40, 0);
        idle(2);
        exp_cap("rst_rec0", 0, 0, 20, 20);
        exp_cap("rst_rec1", 1, 1, 30, 30);

        // randomized traffic with ratio changes, resyncs and flushes
        drv_lr = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 4) drv_lr = $urandom_range(7);
            v = ($urandom_range(99) < 75);
            f = ($urandom_range(99) < 3);
            c = ($urandom_range(249) == 0);
            case ($urandom_range(9))
                0:       d = 8388607;
                1:       d = -8388608;
                default: d = int'($signed($urandom)) >>> 8;
            endcase
            step(v, f, d, c);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
